pht_update_queue: RTL

- Buffers conditional-branch results from the integer/branch execution pipes and drains them as PHT counter writes into the gshare PHT.
- Sits between branch resolution (BranchResult producers) and the single-ported PHT array, which the fetch stage reads.
- Computes the gshare index and the saturated 2-bit counter for each update.
- Holds up to QUEUE_SIZE pending writes and issues at most one write per cycle, only when the fetch read does not claim the array port.

---
 rtl/pht_update_queue_if.sv | 44 ++++
 rtl/pht_update_queue.sv | 116 +++++++++++
 2 files changed

// File: rtl/pht_update_queue_if.sv
// pht_update_queue_if
//   Bundles the branch-result input lanes, the PHT write port and the queue
//   status outputs of pht_update_queue.
//   master : branch-resolution / fetch side (drives br_*, pht_port_busy)
//   slave  : the update queue (drives pht_we/pht_wa/pht_wv and status)
//   br_valid/br_is_cond/br_exec_taken : one bit per lane, lane 0 oldest
//   br_addr, br_global_history, br_prev_counter : lanes packed LSB-first
//   pht_we/pht_wa/pht_wv : PHT write enable, index, 2-bit counter value
//   q_empty/q_full/q_count/drop_count : occupancy and dropped-update count
interface pht_update_queue_if #(
  parameter int unsigned INPUT_NUM       = 2,
  parameter int unsigned QUEUE_SIZE      = 32,
  parameter int unsigned PHT_INDEX_WIDTH = 11,
  parameter int unsigned GH_WIDTH        = 10,
  parameter int unsigned PC_WIDTH        = 32,
  parameter int unsigned DROP_CNT_WIDTH  = 16
);
  logic [INPUT_NUM-1:0]          br_valid;
  logic [INPUT_NUM-1:0]          br_is_cond;
  logic [INPUT_NUM*PC_WIDTH-1:0] br_addr;
  logic [INPUT_NUM*GH_WIDTH-1:0] br_global_history;
  logic [INPUT_NUM-1:0]          br_exec_taken;
  logic [INPUT_NUM*2-1:0]        br_prev_counter;
  logic                          pht_port_busy;
  logic                          pht_we;
  logic [PHT_INDEX_WIDTH-1:0]    pht_wa;
  logic [1:0]                    pht_wv;
  logic                          q_empty;
  logic                          q_full;
  logic [$clog2(QUEUE_SIZE):0]   q_count;
  logic [DROP_CNT_WIDTH-1:0]     drop_count;

  modport master (
    output br_valid, br_is_cond, br_addr, br_global_history, br_exec_taken,
           br_prev_counter, pht_port_busy,
    input  pht_we, pht_wa, pht_wv, q_empty, q_full, q_count, drop_count
  );

  modport slave (
    input  br_valid, br_is_cond, br_addr, br_global_history, br_exec_taken,
           br_prev_counter, pht_port_busy,
    output pht_we, pht_wa, pht_wv, q_empty, q_full, q_count, drop_count
  );
endinterface

// File: rtl/pht_update_queue.sv
// pht_update_queue
//   Buffers resolved conditional-branch results and drains them, oldest
//   first, as gshare PHT counter writes whenever fetch is not reading the
//   single-ported PHT. Index and saturated counter are computed at enqueue.
//   Ports: clk, rst (synchronous, active-high), io (pht_update_queue_if.slave).
//   Optional feature macro: PHT_UPDATE_BYPASS_EN -- when the queue is empty
//   and the port is free, lane 0 is written to the PHT in the same cycle
//   instead of being enqueued.
module pht_update_queue #(
  parameter int unsigned INPUT_NUM       = 2,
  parameter int unsigned QUEUE_SIZE      = 32,
  parameter int unsigned PHT_INDEX_WIDTH = 11,
  parameter int unsigned GH_WIDTH        = 10,
  parameter int unsigned PC_WIDTH        = 32,
  parameter int unsigned DROP_CNT_WIDTH  = 16
) (
  input logic                clk,
  input logic                rst,
  pht_update_queue_if.slave  io
);
  localparam int unsigned PTR_W   = $clog2(QUEUE_SIZE);
  localparam int unsigned CNT_W   = PTR_W + 1;
  localparam int unsigned ENTRY_W = PHT_INDEX_WIDTH + 2;
  localparam int unsigned DROP_W1 = DROP_CNT_WIDTH + 1;

  logic [ENTRY_W-1:0]         mem [QUEUE_SIZE];
  logic [PTR_W-1:0]           head, tail;
  logic [CNT_W-1:0]           count;
  logic [DROP_CNT_WIDTH-1:0]  dropCnt;

  logic [INPUT_NUM-1:0]       qual, qualEnq, wrEn;
  logic [PHT_INDEX_WIDTH-1:0] idx [INPUT_NUM];
  logic [1:0]                 ctr [INPUT_NUM];
  logic [PTR_W-1:0]           wrPtr [INPUT_NUM];
  logic [CNT_W-1:0]           freeSlots, nEnq, nDrop;
  logic [DROP_W1-1:0]         dropSum;
  logic                       empty, deq, bypass;
  logic                       unusedAddrBits;

  assign empty = (count == '0);
  assign deq   = !rst && !empty && !io.pht_port_busy;

`ifdef PHT_UPDATE_BYPASS_EN
  assign bypass = !rst && empty && !io.pht_port_busy && qual[0];
`else
  assign bypass = 1'b0;
`endif

  // Per-lane qualification, gshare index and saturated counter.
  always_comb begin
    for (int unsigned i = 0; i < INPUT_NUM; i++) begin
      logic [PHT_INDEX_WIDTH-1:0] ghExt;
      logic [1:0]                 prev;
      ghExt = '0;
      ghExt[GH_WIDTH-1:0] = io.br_global_history[i*GH_WIDTH +: GH_WIDTH];
      prev    = io.br_prev_counter[i*2 +: 2];
      qual[i] = io.br_valid[i] && io.br_is_cond[i];
      idx[i]  = io.br_addr[i*PC_WIDTH+2 +: PHT_INDEX_WIDTH] ^ ghExt;
      if (io.br_exec_taken[i]) ctr[i] = (prev == 2'd3) ? 2'd3 : prev + 2'd1;
      else                     ctr[i] = (prev == 2'd0) ? 2'd0 : prev - 2'd1;
    end
  end

  // Slot allocation in lane order against start-of-cycle free space; once
  // space runs out every later (younger) qualifying lane is dropped.
  always_comb begin
    qualEnq    = qual;
    qualEnq[0] = qual[0] && !bypass;
    freeSlots  = CNT_W'(QUEUE_SIZE) - count;
    wrEn       = '0;
    nEnq       = '0;
    nDrop      = '0;
    for (int unsigned i = 0; i < INPUT_NUM; i++) begin
      wrPtr[i] = tail + nEnq[PTR_W-1:0];
      if (qualEnq[i]) begin
        if (nEnq < freeSlots) begin
          wrEn[i] = 1'b1;
          nEnq    = nEnq + CNT_W'(1);
        end else begin
          nDrop   = nDrop + CNT_W'(1);
        end
      end
    end
    dropSum = {1'b0, dropCnt} + DROP_W1'(nDrop);
  end

  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < INPUT_NUM; i++)
      if (!rst && wrEn[i]) mem[wrPtr[i]] <= {idx[i], ctr[i]};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head    <= '0;
      tail    <= '0;
      count   <= '0;
      dropCnt <= '0;
    end else begin
      if (deq) head <= head + PTR_W'(1);
      tail    <= tail + nEnq[PTR_W-1:0];
      count   <= count + nEnq - CNT_W'(deq);
      dropCnt <= dropSum[DROP_CNT_WIDTH] ? '1 : dropSum[DROP_CNT_WIDTH-1:0];
    end
  end

  assign io.pht_we     = deq || bypass;
  assign io.pht_wa     = bypass ? idx[0] : mem[head][ENTRY_W-1:2];
  assign io.pht_wv     = bypass ? ctr[0] : mem[head][1:0];
  assign io.q_empty    = empty;
  assign io.q_full     = (count == CNT_W'(QUEUE_SIZE));
  assign io.q_count    = count;
  assign io.drop_count = dropCnt;

  // Only bits [PHT_INDEX_WIDTH+1:2] of each branch PC feed the index.
  assign unusedAddrBits = ^io.br_addr;
endmodule
